round_robin_bus_scheduler: RTL and testbench
============================================

Name: round_robin_bus_scheduler

Overview:
- Shares one datapath resource between NUMBER_OF_REQUESTERS requesters.
- Grants ownership with round-robin fairness and holds the grant until the owner releases or a hold timeout expires.
- Drives the select input of the Demultiplexer and Multiplexer pair that route the shared resource, plus a one-hot grant vector back to the requesters.

Parameters:
- NUMBER_OF_REQUESTERS, 4, number of requesters. Must be at least 2.
- SELECT_WIDTH, $clog2(NUMBER_OF_REQUESTERS), width of select and of the owner index.
- MAX_HOLD_CYCLES, 16, maximum consecutive cycles one owner keeps the grant. Must be at least 1.
- HOLD_COUNTER_WIDTH, $clog2(MAX_HOLD_CYCLES + 1), width of the hold counter.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- requests, input, NUMBER_OF_REQUESTERS, bit i high means requester i wants the resource. Level, held until granted.
- releases, input, NUMBER_OF_REQUESTERS, bit i high means requester i gives up ownership. Only the current owner's bit is honoured.
- grants, output, NUMBER_OF_REQUESTERS, one-hot or zero; bit i high means requester i owns the resource.
- select, output, SELECT_WIDTH, index of the owner; feeds the demux/mux select.
- busy, output, 1, high while any grant is active.
- timeoutPulse, output, 1, one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; grants=0, select=0, busy=0, timeoutPulse=0.
  - priority pointer=0, hold counter=0.
  - Asserting reset mid-grant drops the grant immediately, not at the next edge.
- States: IDLE and GRANTED. Registered outputs only; no combinational path from requests to grants.
- IDLE:
  - At each edge with requests!=0, choose the first i with requests[i]=1, scanning from the pointer upward and wrapping modulo NUMBER_OF_REQUESTERS.
  - Then set grants=onehot(i), select=i, busy=1, hold counter=1, and go to GRANTED.
  - Latency: a request sampled at edge k gives a visible grant after edge k.
  - With requests==0, stay in IDLE with outputs at 0; select keeps its last value.
- GRANTED, owner o:
  - Release: at an edge with releases[o]=1 or requests[o]=0, go to IDLE, set grants=0, busy=0, pointer=(o+1) mod N.
  - Timeout: else, if hold counter==MAX_HOLD_CYCLES, revoke exactly as for release and pulse timeoutPulse=1 for one cycle.
  - Hold: otherwise increment the hold counter; grants and select stay stable.
- Release and timeout on the same edge: treated as a release; timeoutPulse stays 0.
- There is always one idle (bubble) cycle between consecutive grants. This guarantees the demux select never changes while grants is non-zero.
- releases bits from non-owners are ignored in every state. releases in IDLE are ignored.
- The pointer advances only on grant end, so a requester keeping requests high cannot starve the others.
- Worst-case wait for a requester with a held request: (N-1)*(MAX_HOLD_CYCLES+1) cycles.
- Invariant, checked by assertion: $onehot0(grants). When busy=1, grants[select]==1.

Test Plan:
- Reset: reset=1 asynchronously mid-cycle while requester 2 owns the resource -> grants=0, busy=0, select=0 before the next clock edge. After release of reset with requests=4'b0001, grants=4'b0001 one edge later.
- Single requester: requests=4'b0100 at edge 0 -> grants=4'b0100, select=2, busy=1 after edge 0. Pulse releases[2] at edge 3 -> grants=0 after edge 3. Pointer becomes 3.
- Round-robin fairness: requests=4'b1111 held; each owner releases after 1 cycle -> grant order 0,1,2,3,0, with one idle cycle between each grant.
- Timeout: MAX_HOLD_CYCLES=4, requests=4'b0011 held, no releases -> requester 0 is granted for 4 cycles, then revoked with timeoutPulse=1 for one cycle. After the idle cycle, requester 1 is granted.
- Foreign release and simultaneous events: requester 1 owns; releases=4'b0100 -> no change. Then releases[1]=1 on the same edge the counter hits MAX_HOLD_CYCLES -> grant ends, timeoutPulse=0.
- Request drop: owner 3 drops requests[3] without releasing -> grants=0 after that edge, pointer wraps to 0.

Source files
------------

// File: rtl/round_robin_bus_scheduler.sv
// Round-robin owner arbitration for one shared datapath resource. It drives the
// demux/mux select and a one-hot grant vector, and revokes a grant after a hold timeout.
module round_robin_bus_scheduler #(
   parameter int NUMBER_OF_REQUESTERS = 4,
   parameter int SELECT_WIDTH         = $clog2(NUMBER_OF_REQUESTERS),
   parameter int MAX_HOLD_CYCLES      = 16,
   parameter int HOLD_COUNTER_WIDTH   = $clog2(MAX_HOLD_CYCLES + 1)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUMBER_OF_REQUESTERS-1:0] requests,
   input  logic [NUMBER_OF_REQUESTERS-1:0] releases,
   output logic [NUMBER_OF_REQUESTERS-1:0] grants,
   output logic [SELECT_WIDTH-1:0]         select,
   output logic                            busy,
   output logic                            timeoutPulse
);

   localparam logic [0:0] STATE_IDLE    = 1'b0;
   localparam logic [0:0] STATE_GRANTED = 1'b1;

   localparam logic [HOLD_COUNTER_WIDTH-1:0]   HOLD_MAX   = HOLD_COUNTER_WIDTH'(MAX_HOLD_CYCLES);
   localparam logic [HOLD_COUNTER_WIDTH-1:0]   HOLD_ONE   = HOLD_COUNTER_WIDTH'(1);
   localparam logic [HOLD_COUNTER_WIDTH-1:0]   HOLD_ZERO  = HOLD_COUNTER_WIDTH'(0);
   localparam logic [SELECT_WIDTH-1:0]         SEL_ZERO   = SELECT_WIDTH'(0);
   localparam logic [SELECT_WIDTH-1:0]         SEL_ONE    = SELECT_WIDTH'(1);
   localparam logic [SELECT_WIDTH-1:0]         LAST_INDEX = SELECT_WIDTH'(NUMBER_OF_REQUESTERS - 1);
   localparam logic [NUMBER_OF_REQUESTERS-1:0] GRANT_NONE = NUMBER_OF_REQUESTERS'(0);
   localparam logic [NUMBER_OF_REQUESTERS-1:0] GRANT_ONE  = NUMBER_OF_REQUESTERS'(1);

   logic [0:0]                      state_q,   state_d;
   logic [NUMBER_OF_REQUESTERS-1:0] grants_q,  grants_d;
   logic [SELECT_WIDTH-1:0]         select_q,  select_d;
   logic                            busy_q,    busy_d;
   logic                            timeout_q, timeout_d;
   logic [SELECT_WIDTH-1:0]         pointer_q, pointer_d;
   logic [HOLD_COUNTER_WIDTH-1:0]   hold_q,    hold_d;

   logic [SELECT_WIDTH-1:0]         winner_s;
   logic                            owner_done_s;
   logic [SELECT_WIDTH-1:0]         next_pointer_s;

   // First set request at or after ptr, wrapping; only meaningful when req != 0.
   function automatic logic [SELECT_WIDTH-1:0] pick_owner(
      input logic [NUMBER_OF_REQUESTERS-1:0] req,
      input logic [SELECT_WIDTH-1:0]         ptr
   );
      logic [SELECT_WIDTH-1:0] result;
      logic                    found;
      int                      idx;
      result = SEL_ZERO;
      found  = 1'b0;
      for (int k = 0; k < NUMBER_OF_REQUESTERS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUMBER_OF_REQUESTERS) begin
            idx = idx - NUMBER_OF_REQUESTERS;
         end else begin
            idx = idx;
         end
         if (!found && req[idx]) begin
            result = SELECT_WIDTH'(idx);
            found  = 1'b1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

   assign winner_s       = pick_owner(requests, pointer_q);
   assign owner_done_s   = releases[select_q] | ~requests[select_q];
   assign next_pointer_s = (select_q == LAST_INDEX) ? SEL_ZERO : select_q + SEL_ONE;

   // Next-state decode for grant, select, hold counter and round-robin pointer.
   always_comb begin
      state_d   = state_q;
      grants_d  = grants_q;
      select_d  = select_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      pointer_d = pointer_q;
      hold_d    = hold_q;
      case (state_q)
         STATE_IDLE: begin
            if (requests != GRANT_NONE) begin
               state_d  = STATE_GRANTED;
               grants_d = GRANT_ONE << winner_s;
               select_d = winner_s;
               busy_d   = 1'b1;
               hold_d   = HOLD_ONE;
            end else begin
               grants_d = GRANT_NONE;
               busy_d   = 1'b0;
            end
         end
         STATE_GRANTED: begin
            // A release on the timeout edge wins, so the pulse only marks a true revoke.
            if (owner_done_s || (hold_q == HOLD_MAX)) begin
               state_d   = STATE_IDLE;
               grants_d  = GRANT_NONE;
               busy_d    = 1'b0;
               hold_d    = HOLD_ZERO;
               pointer_d = next_pointer_s;
               timeout_d = ~owner_done_s;
            end else begin
               hold_d = hold_q + HOLD_ONE;
            end
         end
         default: begin
            state_d  = STATE_IDLE;
            grants_d = GRANT_NONE;
            busy_d   = 1'b0;
            hold_d   = HOLD_ZERO;
         end
      endcase
   end

   // State registers; reset drops any grant without waiting for an edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= STATE_IDLE;
         grants_q  <= GRANT_NONE;
         select_q  <= SEL_ZERO;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         pointer_q <= SEL_ZERO;
         hold_q    <= HOLD_ZERO;
      end else begin
         state_q   <= state_d;
         grants_q  <= grants_d;
         select_q  <= select_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         pointer_q <= pointer_d;
         hold_q    <= hold_d;
      end
   end

   assign grants       = grants_q;
   assign select       = select_q;
   assign busy         = busy_q;
   assign timeoutPulse = timeout_q;

   round_robin_bus_scheduler_checker #(
      .NUMBER_OF_REQUESTERS(NUMBER_OF_REQUESTERS),
      .SELECT_WIDTH        (SELECT_WIDTH)
   ) u_checker (
      .clock       (clock),
      .reset       (reset),
      .grants      (grants_q),
      .select      (select_q),
      .busy        (busy_q),
      .timeoutPulse(timeout_q)
   );

endmodule

// Output invariants of the scheduler: at most one grant, and the selected
// requester is the one holding it whenever the resource is busy.
module round_robin_bus_scheduler_checker #(
   parameter int NUMBER_OF_REQUESTERS = 4,
   parameter int SELECT_WIDTH         = 2
) (
   input logic                            clock,
   input logic                            reset,
   input logic [NUMBER_OF_REQUESTERS-1:0] grants,
   input logic [SELECT_WIDTH-1:0]         select,
   input logic                            busy,
   input logic                            timeoutPulse
);

   grants_onehot0_a: assert property (@(posedge clock) disable iff (reset)
      $onehot0(grants));

   busy_selects_owner_a: assert property (@(posedge clock) disable iff (reset)
      busy |-> grants[select]);

   busy_matches_grants_a: assert property (@(posedge clock) disable iff (reset)
      busy == (grants != NUMBER_OF_REQUESTERS'(0)));

   timeout_only_when_idle_a: assert property (@(posedge clock) disable iff (reset)
      timeoutPulse |-> !busy);

endmodule

// File: tb/tb_round_robin_bus_scheduler.sv
// Directed, table-driven bench for round_robin_bus_scheduler (4 requesters, hold limit 4).
module tb_round_robin_bus_scheduler;

   localparam int N   = 4;
   localparam int SW  = 2;
   localparam int MAX = 4;

   logic          clock;
   logic          reset;
   logic [N-1:0]  requests;
   logic [N-1:0]  releases;
   logic [N-1:0]  grants;
   logic [SW-1:0] select;
   logic          busy;
   logic          timeoutPulse;

   int errors;
   int checks;

   typedef struct {
      logic [N-1:0]  req;
      logic [N-1:0]  rel;
      logic [N-1:0]  g;
      logic [SW-1:0] sel;
      logic          b;
      logic          to;
   } vec_t;

   vec_t vecs[$];

   round_robin_bus_scheduler #(
      .NUMBER_OF_REQUESTERS(N),
      .MAX_HOLD_CYCLES     (MAX)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .requests    (requests),
      .releases    (releases),
      .grants      (grants),
      .select      (select),
      .busy        (busy),
      .timeoutPulse(timeoutPulse)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [N-1:0] g, input logic [SW-1:0] sel,
                                input logic b, input logic to);
      check({tag, ".grants"},       32'(grants),       32'(g));
      check({tag, ".select"},       32'(select),       32'(sel));
      check({tag, ".busy"},         32'(busy),         32'(b));
      check({tag, ".timeoutPulse"}, 32'(timeoutPulse), 32'(to));
   endtask

   task automatic add(input logic [N-1:0] req, input logic [N-1:0] rel, input logic [N-1:0] g,
                      input logic [SW-1:0] sel, input logic b, input logic to);
      vec_t v;
      v.req = req; v.rel = rel; v.g = g; v.sel = sel; v.b = b; v.to = to;
      vecs.push_back(v);
   endtask

   task automatic step(input logic [N-1:0] req, input logic [N-1:0] rel);
      requests = req;
      releases = rel;
      @(posedge clock);
      #1;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      reset    = 1'b1;
      requests = 4'b0000;
      releases = 4'b0000;

      // Single requester: grant to 2, hold three cycles, release -> pointer 3
      add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      add(4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
      // Round-robin with all requesting: 3,0,1,2,3,0 with a bubble between
      add(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
      add(4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);
      add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      add(4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
      add(4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
      add(4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
      add(4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0);
      add(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
      add(4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0);
      add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      add(4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
      // Move pointer to 2 so that 0 wins the 4'b0011 timeout scenario
      add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
      // Timeout: 0 held 4 cycles, revoked with pulse, then 1 granted
      add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      add(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
      add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      // Foreign release ignored, then own release on the timeout edge
      add(4'b0011, 4'b0100, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(4'b0011, 4'b0100, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(4'b0011, 4'b0100, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(4'b0011, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0);
      // Request drop by owner 3 wraps pointer to 0
      add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
      add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      // Idle with a stray release: nothing happens, select keeps its value
      add(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);

      #12;
      check_outputs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].req, vecs[i].rel);
         check_outputs($sformatf("vec%0d", i), vecs[i].g, vecs[i].sel, vecs[i].b, vecs[i].to);
      end

      // Asynchronous reset while requester 2 owns (pointer is 1 here)
      step(4'b0100, 4'b0000);
      check_outputs("own2", 4'b0100, 2'd2, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      check_outputs("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      step(4'b0001, 4'b0000);
      check_outputs("post_reset", 4'b0001, 2'd0, 1'b1, 1'b0);

      // Pointer must also clear on reset: advance it to 1, reset, then 0 must win
      step(4'b0001, 4'b0001);
      check_outputs("rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
      step(4'b0010, 4'b0000);
      check_outputs("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      check_outputs("async_reset2", 4'b0000, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      step(4'b0011, 4'b0000);
      check_outputs("ptr_cleared", 4'b0001, 2'd0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
